// File: rtl/inv_mix_column_seq.sv
// Sequential AES InvMixColumns: latches a 128-bit state, inverse-mixes
// COLS_PER_CYCLE columns per clock, then holds the result until consumed.
module inv_mix_column_seq #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  localparam int unsigned COL_W   = 4 * DATA_WIDTH;
  localparam int unsigned STATE_W = 4 * COL_W;
  localparam int unsigned NCYC    = 4 / COLS_PER_CYCLE;
  localparam int unsigned CW      = (NCYC > 1) ? $clog2(NCYC) : 1;

  // Reject unsupported configurations at elaboration.
  generate
    if (!((COLS_PER_CYCLE == 1) || (COLS_PER_CYCLE == 2) || (COLS_PER_CYCLE == 4))
        || (DATA_WIDTH != 8)) begin : g_bad_param
      $error("inv_mix_column_seq: COLS_PER_CYCLE must be 1, 2 or 4 and DATA_WIDTH must be 8");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e              state_q;
  logic [CW-1:0]       col_idx_q;
  logic [STATE_W-1:0]  st_q;
  logic [STATE_W-1:0]  st_d;
  logic                out_valid_q;

  // GF(2^8) multiply by x, reduction polynomial 0x11B.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One column through the [0e 0b 0d 09] circulant; row 0 is the top byte.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a  [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    logic [31:0] res;
    res = '0;
    for (int r = 0; r < 4; r++) begin
      a[r]  = col[31-8*r -: 8];
      x2    = xtime(a[r]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[r] = x8 ^ a[r];
      mb[r] = x8 ^ x2 ^ a[r];
      md[r] = x8 ^ x4 ^ a[r];
      me[r] = x8 ^ x4 ^ x2;
    end
    for (int r = 0; r < 4; r++) begin
      res[31-8*r -: 8] = me[r] ^ mb[2'(r+1)] ^ md[2'(r+2)] ^ m9[2'(r+3)];
    end
    return res;
  endfunction

  // MSB position of column c inside the packed state.
  function automatic int unsigned col_msb(input int unsigned c);
    return STATE_W - 1 - COL_W * c;
  endfunction

  // Working state with the current column group replaced by its mixed value.
  always_comb begin
    st_d = st_q;
    for (int unsigned k = 0; k < COLS_PER_CYCLE; k++) begin
      st_d[col_msb(32'(col_idx_q) * COLS_PER_CYCLE + k) -: COL_W] =
        inv_mix_col(st_q[col_msb(32'(col_idx_q) * COLS_PER_CYCLE + k) -: COL_W]);
    end
  end

  // Control FSM, column counter and working register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      col_idx_q   <= '0;
      st_q        <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            st_q      <= in_data;
            col_idx_q <= '0;
            state_q   <= BUSY;
          end
        end
        BUSY: begin
          st_q <= st_d;
          if (col_idx_q == CW'(NCYC - 1)) begin
            col_idx_q   <= '0;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            col_idx_q <= col_idx_q + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = st_q;

endmodule

// File: tb/tb_inv_mix_column_seq.sv
// Scoreboard bench for inv_mix_column_seq: directed FIPS-197 columns,
// backpressure, random round trips through a forward MixColumns model,
// mid-operation reset and a COLS_PER_CYCLE sweep.
module tb_inv_mix_column_seq;

  localparam logic [127:0] V1_IN  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] V1_OUT = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] V2_IN  = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;
  localparam logic [127:0] V2_OUT = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         rdy_man;
  logic         rdy_mode;
  logic         rnd_bit = 1'b1;

  logic         iv2, ir2, ov2, iv4, ir4, ov4;
  logic [127:0] id2, od2, id4, od4;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [127:0] exp_q[$];
  int           acc_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    #1 rnd_bit = 1'($urandom_range(0, 1));
  end
  assign out_ready = rdy_mode ? rnd_bit : rdy_man;

  inv_mix_column_seq #(.DATA_WIDTH(8), .COLS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data));

  inv_mix_column_seq #(.DATA_WIDTH(8), .COLS_PER_CYCLE(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .in_data(id2),
    .out_valid(ov2), .out_ready(1'b1), .out_data(od2));

  inv_mix_column_seq #(.DATA_WIDTH(8), .COLS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .in_data(id4),
    .out_valid(ov4), .out_ready(1'b1), .out_data(od4));

  task automatic chk(input logic ok, input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Forward (encrypt-side) MixColumns model.
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mixcol(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24]; a1 = c[23:16]; a2 = c[15:8]; a3 = c[7:0];
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction

  function automatic logic [127:0] mix128(input logic [127:0] s);
    return {mixcol(s[127:96]), mixcol(s[95:64]), mixcol(s[63:32]), mixcol(s[31:0])};
  endfunction

  // Monitor: pops the scoreboard on every output handshake.
  logic         ov_prev = 1'b0;
  logic         hold    = 1'b0;
  logic [127:0] held    = '0;
  always @(negedge clk) begin
    logic [127:0] e;
    if (rst) begin
      ov_prev = 1'b0;
      hold    = 1'b0;
    end else begin
      if (out_valid)
        chk(in_ready == 1'b0, "in_ready_while_done", 128'(in_ready), 128'(0));
      if (out_valid && !ov_prev) begin
        if (acc_q.size() == 0)
          chk(1'b0, "spurious_out_valid", 128'(out_valid), 128'(0));
        else
          chk((cyc - acc_q[0]) == 4, "latency", 128'(cyc - acc_q[0]), 128'(4));
      end
      if (hold && out_valid)
        chk(out_data == held, "hold_stable", out_data, held);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_output", out_data, 128'(0));
        end else begin
          e = exp_q.pop_front();
          void'(acc_q.pop_front());
          chk(out_data == e, "out_data", out_data, e);
        end
        hold = 1'b0;
      end else if (out_valid) begin
        hold = 1'b1;
        held = out_data;
      end else begin
        hold = 1'b0;
      end
      ov_prev = out_valid;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer a state until accepted; record expected result and accept edge.
  task automatic send(input logic [127:0] d, input logic [127:0] e);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 200) begin
      step();
      n++;
    end
    if (!in_ready) begin
      chk(in_ready, "accept_timeout", 128'(in_ready), 128'(1));
    end else begin
      exp_q.push_back(e);
      acc_q.push_back(cyc + 1);
    end
    step();
    in_valid = 1'b0;
    in_data  = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      step();
      n++;
    end
    chk(exp_q.size() == 0, "drain_timeout", 128'(exp_q.size()), 128'(0));
  endtask

  task automatic wait_ov();
    int n;
    n = 0;
    while (!out_valid && n < 50) begin
      step();
      n++;
    end
    chk(out_valid, "wait_out_valid", 128'(out_valid), 128'(1));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk(out_valid == 1'b0, {tag, "_out_valid"}, 128'(out_valid), 128'(0));
    chk(out_data == '0, {tag, "_out_data"}, out_data, 128'(0));
    chk(in_ready == 1'b1, {tag, "_in_ready"}, 128'(in_ready), 128'(1));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int a;
    int n;
    logic [127:0] d;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; rdy_man = 1'b1; rdy_mode = 1'b0;
    iv2 = 1'b0; id2 = '0; iv4 = 1'b0; id4 = '0;
    step(); step();
    chk_reset_outputs("reset");
    rst = 1'b0;
    step();

    // Directed FIPS-197 vectors.
    send(V1_IN, V1_OUT);
    drain();
    send(V2_IN, V2_OUT);
    drain();

    // Backpressure: result held for 10 cycles while a second state waits.
    rdy_man = 1'b0;
    send(V1_IN, V1_OUT);
    in_valid = 1'b1;
    in_data  = V2_IN;
    wait_ov();
    for (int i = 0; i < 10; i++) begin
      step();
      chk(in_ready == 1'b0, "bp_in_ready", 128'(in_ready), 128'(0));
      chk(out_data == V1_OUT, "bp_out_data", out_data, V1_OUT);
    end
    rdy_man = 1'b1;
    step();
    chk(out_valid == 1'b0, "bp_out_valid_fall", 128'(out_valid), 128'(0));
    chk(in_ready == 1'b1, "bp_in_ready_rise", 128'(in_ready), 128'(1));
    exp_q.push_back(V2_OUT);
    acc_q.push_back(cyc + 1);
    step();
    in_valid = 1'b0;
    chk(in_ready == 1'b0, "bp_second_taken", 128'(in_ready), 128'(0));
    drain();

    // Random round trips through the forward mixer with ready/valid gaps.
    rdy_mode = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      repeat ($urandom_range(0, 2)) step();
      send(mix128(d), d);
    end
    drain();
    rdy_mode = 1'b0;

    // Reset while BUSY.
    send(V2_IN, V2_OUT);
    step();
    rst = 1'b1;
    exp_q.delete();
    acc_q.delete();
    #1;
    chk_reset_outputs("rst_busy");
    step();
    rst = 1'b0;
    send(V1_IN, V1_OUT);
    drain();

    // Reset while DONE with a pending result.
    rdy_man = 1'b0;
    send(V2_IN, V2_OUT);
    wait_ov();
    step();
    rst = 1'b1;
    exp_q.delete();
    acc_q.delete();
    #1;
    chk_reset_outputs("rst_done");
    step();
    rst = 1'b0;
    rdy_man = 1'b1;
    send(V2_IN, V2_OUT);
    drain();

    // COLS_PER_CYCLE=2: two-edge latency.
    chk(ir2 == 1'b1, "cpc2_in_ready", 128'(ir2), 128'(1));
    iv2 = 1'b1; id2 = V1_IN;
    a = cyc + 1;
    step();
    iv2 = 1'b0;
    n = 0;
    while (!ov2 && n < 20) begin step(); n++; end
    chk(ov2 == 1'b1, "cpc2_out_valid", 128'(ov2), 128'(1));
    chk((cyc - a) == 2, "cpc2_latency", 128'(cyc - a), 128'(2));
    chk(od2 == V1_OUT, "cpc2_out_data", od2, V1_OUT);

    // COLS_PER_CYCLE=4: one-edge latency.
    step();
    chk(ir4 == 1'b1, "cpc4_in_ready", 128'(ir4), 128'(1));
    iv4 = 1'b1; id4 = V1_IN;
    a = cyc + 1;
    step();
    iv4 = 1'b0;
    n = 0;
    while (!ov4 && n < 20) begin step(); n++; end
    chk(ov4 == 1'b1, "cpc4_out_valid", 128'(ov4), 128'(1));
    chk((cyc - a) == 1, "cpc4_latency", 128'(cyc - a), 128'(1));
    chk(od4 == V1_OUT, "cpc4_out_data", od4, V1_OUT);

    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
